// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

  localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive fetch losses at grant time; asks for a forced fetch win at the limit.
module mem_arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_cycle,
  input  logic if_lost,
  input  logic if_won,
  input  logic halt_sys,
  output logic force_if
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (grant_cycle && !halt_sys) begin
      if (if_won) begin
        cnt_d = '0;
      end else if (if_lost) begin
        cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
      end else begin
        // No fetch pending at this grant: nothing is being starved.
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_if = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto the single-ported main memory:
// latch winner, one access cycle, one ack cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_sys,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              misaligned,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_data_out
);

  arb_state_t        state_q, state_d;
  req_id_t           id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mis_q, mis_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic grant_cycle, win_if, force_if;

  assign grant_cycle = (state_q == ARB_IDLE) && (if_req || dm_req);
  assign win_if      = if_req && (!dm_req || force_if);

  mem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .grant_cycle(grant_cycle),
    .if_lost    (if_req && !win_if),
    .if_won     (win_if),
    .halt_sys   (halt_sys),
    .force_if   (force_if)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    if (!halt_sys) begin
      case (state_q)
        ARB_IDLE: begin
          if (grant_cycle) begin
            state_d = ARB_ACCESS;
            if (win_if) begin
              id_d   = REQ_IF;
              addr_d = {if_addr[ADDR_W-1:1], 1'b0};
              we_d   = 1'b0;
              mis_d  = if_addr[0];
            end else begin
              id_d    = REQ_DM;
              addr_d  = {dm_addr[ADDR_W-1:1], 1'b0};
              we_d    = dm_we;
              wdata_d = dm_wdata;
              mis_d   = dm_addr[0];
            end
          end
        end
        ARB_ACCESS: begin
          rdata_d = mem_data_out;
          state_d = ARB_RESP;
        end
        ARB_RESP: state_d = ARB_IDLE;
        default:  state_d = ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    if_ack       = 1'b0;
    dm_ack       = 1'b0;
    misaligned   = 1'b0;
    mem_write_en = 1'b0;
    if (!halt_sys) begin
      mem_write_en = (state_q == ARB_ACCESS) && we_q;
      if (state_q == ARB_RESP) begin
        if_ack     = (id_q == REQ_IF);
        dm_ack     = (id_q == REQ_DM);
        misaligned = mis_q;
      end
    end
  end

  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign rdata          = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      id_q    <= REQ_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// against a transaction-level model of arbitration, latency and memory contents.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        halt_sys = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_ack;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [15:0] dm_addr = '0;
  logic [15:0] dm_wdata = '0;
  logic        dm_ack;
  logic [15:0] rdata;
  logic        misaligned;
  logic        mem_write_en;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic [15:0] mem_data_out;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .rdata(rdata), .misaligned(misaligned),
    .mem_write_en(mem_write_en), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_data_out(mem_data_out)
  );

  function automatic logic [15:0] init_word(int idx);
    return 16'((idx * 40503) ^ 16'hC3A5);
  endfunction

  // Main-memory stand-in: combinational read, write at the clock edge.
  logic [15:0] stub [0:255];
  bit          stub_wr [0:255];
  always @(posedge clk) begin
    if (mem_write_en) begin
      stub[mem_address[8:1]]    <= mem_write_data;
      stub_wr[mem_address[8:1]] <= 1'b1;
    end
  end
  assign mem_data_out = stub_wr[mem_address[8:1]] ? stub[mem_address[8:1]]
                                                  : init_word(int'(mem_address[8:1]));

  // Reference memory contents.
  logic [15:0] ref_mem [int];
  function automatic logic [15:0] ref_rd(logic [15:0] a);
    int idx = int'(a[8:1]);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
  endfunction

  int vecs = 0;
  int miss = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction model: one outstanding access; steps_left 1 = access ahead, 0 = ack now.
  bit          m_pend;
  int          m_left;
  bit          m_who;       // 0 fetch, 1 data
  logic [15:0] m_addr, m_wdata, m_rdata, m_last_addr, m_last_wdata;
  bit          m_we, m_mis, m_wd_valid;
  int          m_losses;

  bit if_busy, dm_busy;
  int p_if, p_dm, p_halt;
  bit halt_force;
  int cyc;
  int if_ack_cyc, dm_ack_cyc, dm_run, wr_cnt, ack_cnt;
  bit last_mis;
  int runs[$];

  task automatic model_reset();
    m_pend = 0; m_left = 0; m_who = 0; m_we = 0; m_mis = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_last_addr = '0; m_last_wdata = '0;
    m_wd_valid = 1; m_losses = 0;
    if_busy = 0; dm_busy = 0;
    if_req = 0; dm_req = 0; dm_we = 0;
  endtask

  task automatic cycle();
    bit ack_now, win_if;
    cyc++;
    if (!if_busy) begin
      if_req = 0;
      if ($urandom_range(0, 99) < p_if) begin
        if_busy = 1; if_req = 1; if_addr = 16'($urandom_range(0, 511));
      end
    end
    if (!dm_busy) begin
      dm_req = 0;
      if ($urandom_range(0, 99) < p_dm) begin
        dm_busy = 1; dm_req = 1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = 16'($urandom_range(0, 511)); dm_wdata = 16'($urandom);
      end
    end
    halt_sys = halt_force || ($urandom_range(0, 99) < p_halt);
    #1;
    ack_now = m_pend && (m_left == 0) && !halt_sys;
    chk("if_ack", if_ack, ack_now && !m_who);
    chk("dm_ack", dm_ack, ack_now && m_who);
    chk("misaligned", misaligned, ack_now && m_mis);
    chk("mem_write_en", mem_write_en, m_pend && (m_left == 1) && m_we && !halt_sys);
    chk("mem_address", mem_address, m_last_addr);
    if (m_wd_valid) chk("mem_write_data", mem_write_data, m_last_wdata);
    if (ack_now) chk("rdata", rdata, m_rdata);
    if (mem_write_en === 1'b1) wr_cnt++;
    if (if_ack === 1'b1) begin
      runs.push_back(dm_run); dm_run = 0; if_ack_cyc = cyc; ack_cnt++;
    end
    if (dm_ack === 1'b1) begin
      dm_run++; dm_ack_cyc = cyc; last_mis = misaligned; ack_cnt++;
    end
    $display("cyc %0d halt=%0b ifq=%0b dmq=%0b if_ack=%0b dm_ack=%0b we=%0b addr=%h rdata=%h",
             cyc, halt_sys, if_req, dm_req, if_ack, dm_ack, mem_write_en, mem_address, rdata);
    @(posedge clk);
    if (!halt_sys) begin
      if (m_pend && m_left == 0) begin
        m_pend = 0;
        if (m_who) dm_busy = 0; else if_busy = 0;
      end else if (m_pend) begin
        m_rdata = ref_rd(m_addr);
        if (m_we) ref_mem[int'(m_addr[8:1])] = m_wdata;
        m_left = 0;
      end else if (if_req || dm_req) begin
        win_if = if_req && (!dm_req || m_losses == LIMIT);
        m_losses = (if_req && !win_if) ? ((m_losses < LIMIT) ? m_losses + 1 : LIMIT) : 0;
        m_pend = 1; m_left = 1;
        if (win_if) begin
          m_who = 0; m_addr = {if_addr[15:1], 1'b0}; m_we = 0; m_mis = if_addr[0];
          m_wd_valid = 0;
        end else begin
          m_who = 1; m_addr = {dm_addr[15:1], 1'b0}; m_we = dm_we; m_mis = dm_addr[0];
          m_wdata = dm_wdata; m_last_wdata = dm_wdata; m_wd_valid = 1;
        end
        m_last_addr = m_addr;
      end
    end
    #1;
  endtask

  task automatic drain();
    p_if = 0; p_dm = 0; p_halt = 0; halt_force = 0;
    for (int i = 0; i < 40 && (if_busy || dm_busy || m_pend); i++) cycle();
    chk("drain_timeout", {30'd0, if_busy, dm_busy}, 32'd0);
  endtask

  task automatic dm_issue(bit we, logic [15:0] a, logic [15:0] d);
    dm_busy = 1; dm_req = 1; dm_we = we; dm_addr = a; dm_wdata = d;
  endtask

  task automatic wait_dm();
    for (int i = 0; i < 40 && dm_busy; i++) cycle();
    chk("dm_timeout", {31'd0, dm_busy}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    halt_sys = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_if_ack", if_ack, 0);
    chk("rst_dm_ack", dm_ack, 0);
    chk("rst_mis", misaligned, 0);
    chk("rst_we", mem_write_en, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_write_data, 0);
    chk("rst_rdata", rdata, 0);
    rst = 0;
  endtask

  initial begin
    int start;
    cyc = 0; dm_run = 0; wr_cnt = 0; ack_cnt = 0; last_mis = 0;
    if_ack_cyc = 0; dm_ack_cyc = 0;
    p_if = 0; p_dm = 0; p_halt = 0; halt_force = 0;
    do_reset();

    // Starvation: both requesters saturate the arbiter.
    runs.delete(); dm_run = 0;
    p_if = 100; p_dm = 100;
    for (int i = 0; i < 60 && runs.size() < 2; i++) cycle();
    chk("starve_if_grants", runs.size(), 2);
    if (runs.size() >= 2) begin
      chk("starve_run0", runs[0], LIMIT);
      chk("starve_run1", runs[1], LIMIT);
    end
    drain();

    // Reset in the middle of a store's access cycle.
    dm_issue(1, 16'h0010, 16'hBEEF);
    cycle();
    #1;
    chk("midstore_we_before", mem_write_en, 1);
    rst = 1;
    #1;
    chk("midstore_we_dropped", mem_write_en, 0);
    chk("midstore_dm_ack", dm_ack, 0);
    chk("midstore_addr", mem_address, 0);
    chk("midstore_rdata", rdata, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    dm_issue(0, 16'h0010, 16'h0000);
    wait_dm();
    chk("midstore_prior", rdata, init_word(8));

    // Simultaneous fetch and load.
    drain();
    if_busy = 1; if_req = 1; if_addr = 16'h0000;
    dm_issue(0, 16'h0020, 16'h0000);
    start = cyc + 1;
    for (int i = 0; i < 20 && (if_busy || dm_busy); i++) cycle();
    chk("sim_dm_latency", dm_ack_cyc - start, 2);
    chk("sim_if_latency", if_ack_cyc - start, 5);

    // Misaligned store then aligned load.
    dm_issue(1, 16'h0031, 16'hA5A5);
    wait_dm();
    chk("mis_flag", last_mis, 1);
    dm_issue(0, 16'h0030, 16'h0000);
    wait_dm();
    chk("mis_load", rdata, 16'hA5A5);
    chk("mis_flag_load", last_mis, 0);

    // Halt during a store's access cycle.
    drain();
    dm_issue(1, 16'h0040, 16'h1234);
    cycle();
    wr_cnt = 0; ack_cnt = 0;
    halt_force = 1;
    repeat (3) cycle();
    chk("halt_no_write", wr_cnt, 0);
    chk("halt_no_ack", ack_cnt, 0);
    halt_force = 0;
    cycle();
    chk("halt_one_write", wr_cnt, 1);
    chk("halt_ack_pending", ack_cnt, 0);
    cycle();
    chk("halt_ack", ack_cnt, 1);
    drain();

    // Random traffic with occasional freezes.
    p_if = 40; p_dm = 40; p_halt = 10;
    repeat (400) cycle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single-ported main memory (`mem_main`). It shares the memory between the instruction-fetch requester (read-only) and the data-memory requester (load/store). It latches the winning request, drives the memory for exactly one access cycle, registers the read word, and returns a one-cycle acknowledge. Data accesses have fixed priority, and a starvation counter guarantees fetch forward progress. It sits between the pipeline's IF/MEM stages and `mem_main`, and honours the system `halt_sys` freeze.

## Interface
- `ADDR_W`, 16, address width (word data at byte addresses `a`/`a+1`)
- `DATA_W`, 16, data width
- `STARVE_LIMIT`, 4, consecutive lost fetch arbitrations before fetch is forced to win (≥1)

- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `halt_sys` in 1: system freeze
- `if_req` in 1: fetch request, held until `if_ack`
- `if_addr` in ADDR_W: fetch address
- `if_ack` out 1: one-cycle fetch completion; `rdata` valid this cycle
- `dm_req` in 1: data request, held until `dm_ack`
- `dm_we` in 1: 1 = store, 0 = load
- `dm_addr` in ADDR_W: data address
- `dm_wdata` in DATA_W: store data
- `dm_ack` out 1: one-cycle data completion; `rdata` valid this cycle for loads
- `rdata` out DATA_W: registered read word
- `misaligned` out 1: pulses with the ack when the served address had bit0 = 1
- `mem_write_en` out 1: to `mem_main.write_en`
- `mem_address` out ADDR_W: to `mem_main.address`
- `mem_write_data` out DATA_W: to `mem_main.write_data`
- `mem_data_out` in DATA_W: from `mem_main.data_out`

## Operation
FSM states are `ARB_IDLE`, `ARB_ACCESS` and `ARB_RESP`.

- **`ARB_IDLE`**
  - If any request is present, register the winner's id, address (bit0 forced 0), `we`, `wdata` and the misalign flag, then go to `ARB_ACCESS`.
  - Otherwise stay in `ARB_IDLE`.
- **`ARB_ACCESS`**
  - Drive `mem_address` from the latched address.
  - Drive `mem_write_en` = latched `we`.
  - Capture `mem_data_out` into `rdata` at the clock edge.
  - Go to `ARB_RESP`.
- **`ARB_RESP`**
  - Assert `ack` for the latched requester, with `misaligned` = latched flag.
  - Go to `ARB_IDLE`.
  - Requests are ignored in this state, because the requester's `req` is still high during its ack cycle.
- **Arbitration**
  - `dm_req` wins over `if_req`.
  - Exception: when `starve_cnt == STARVE_LIMIT` and `if_req` = 1, fetch wins.
- **`starve_cnt`** (width `$clog2(STARVE_LIMIT+1)`), updated only on `ARB_IDLE` grant cycles:
  - Increments, saturating, when fetch loses.
  - Clears when fetch wins, or when `if_req` = 0 at a grant.
- **Stores:** `rdata` captures the pre-write word, which callers ignore.
- **Non-`ARB_ACCESS` states:**
  - `mem_write_en` = 0.
  - `mem_address` and `mem_write_data` hold the latched values.
- **`halt_sys` = 1**
  - The FSM, latches and `starve_cnt` hold.
  - `mem_write_en`, `if_ack`, `dm_ack` and `misaligned` are forced to 0.
  - On release the held state resumes. A held `ARB_ACCESS` re-performs its access; a held `ARB_RESP` then issues its ack.
- **Reset, including mid-access:**
  - All outputs 0; `rdata` = 0; `starve_cnt` = 0; state `ARB_IDLE`.
  - A store in flight is dropped (no write).

## Timing
- Request seen in `ARB_IDLE` at edge N → access in cycle N+1 → ack in cycle N+2.
- Latency is 2 cycles; throughput is one access per 3 cycles.
- Back-to-back: after the ack cycle the FSM is in `ARB_IDLE`, so a held competing request is granted at the next edge.
- Simultaneous `if_req` and `dm_req` in `ARB_IDLE`: exactly one is granted; the loser keeps `req` high and waits.
- `ack` is never asserted for a requester whose `req` was low at grant.
- `ack` is never asserted for two requesters in the same cycle.

## Structure
- Package `mem_arb_pkg` holds:
  - `arb_state_t` {`ARB_IDLE`, `ARB_ACCESS`, `ARB_RESP`}
  - `req_id_t` {`REQ_IF`, `REQ_DM`}
  - default `STARVE_LIMIT`
- Sub-module `mem_arb_starve_ctr` contains the saturating counter.
  - Inputs: `grant_cycle`, `if_lost`, `if_won`, `halt_sys`.
  - Output: `force_if`.
- The top level holds the FSM, request latches and the `rdata` register.

## Test plan
- **Reset:** assert `rst` mid-store in `ARB_ACCESS` (`dm_we`=1, addr 0x0010, data 0xBEEF) → `mem_write_en` drops immediately; all outputs 0; a later read of 0x0010 returns the prior contents.
- **Simultaneous requests:** `if_req` (0x0000) and `dm_req` load (0x0020) together → `dm_ack` at N+2; `if_ack` at N+5; each `rdata` matches the memory model.
- **Starvation:** `dm_req` held continuously with `if_req` held and `STARVE_LIMIT`=4 → four dm grants, then one if grant, then dm again; `starve_cnt` returns to 0.
- **Misaligned store:** store 0xA5A5 to 0x0031 → write to 0x0030; `misaligned`=1 with `dm_ack`; load of 0x0030 returns 0xA5A5.
- **Halt:** raise `halt_sys` during `ARB_ACCESS` of a store for 3 cycles → no write and no ack while halted; one write on the cycle after release; ack one cycle later.
